// File: rtl/computer_pkg.sv
// Shared encodings for the accumulator computer: sequencer states,
// instruction opcodes, ALU opcodes and datapath mux selects.
package computer_pkg;

   typedef enum logic [3:0] {
      S_HALT,
      S_F0,
      S_F1,
      S_F2,
      S_F3,
      S_DEC,
      S_E0,
      S_E1,
      S_E2,
      S_E3
   } state_t;

   // Instruction opcodes, ir[15:12]
   localparam logic [3:0] OP_HALT  = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_SHL   = 4'h8;
   localparam logic [3:0] OP_SHR   = 4'h9;
   localparam logic [3:0] OP_JUMP  = 4'hA;
   localparam logic [3:0] OP_JUMPZ = 4'hB;
   localparam logic [3:0] OP_JUMPN = 4'hC;

   // ALU opcodes, shared with the ALU
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_SHL = 4'b0100;
   localparam logic [3:0] ALU_SHR = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b1000;
   localparam logic [3:0] ALU_OR  = 4'b1001;
   localparam logic [3:0] ALU_XOR = 4'b1010;

   // Datapath mux selects
   localparam logic PC_SEL_INC  = 1'b0;
   localparam logic PC_SEL_IR   = 1'b1;
   localparam logic MAR_SEL_PC  = 1'b0;
   localparam logic MAR_SEL_IR  = 1'b1;
   localparam logic MBR_SEL_MEM = 1'b0;
   localparam logic MBR_SEL_ACC = 1'b1;
   localparam logic ACC_SEL_MBR = 1'b0;
   localparam logic ACC_SEL_ALU = 1'b1;

   typedef enum logic [2:0] {
      IC_MEM_ALU,
      IC_LOAD,
      IC_STORE,
      IC_SHIFT,
      IC_JUMP,
      IC_HALT,
      IC_ILLEGAL
   } iclass_t;

   typedef enum logic [1:0] {
      JC_NONE,
      JC_ALWAYS,
      JC_ZERO,
      JC_NEG
   } jcond_t;

   // Resolves a branch condition against the accumulator flags.
   function automatic logic branch_taken(input jcond_t cond, input logic zero, input logic neg);
      logic taken;
      case (cond)
         JC_ALWAYS: taken = 1'b1;
         JC_ZERO:   taken = zero;
         JC_NEG:    taken = neg;
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: instruction class, ALU opcode and branch
// condition for the sequencer.
module instr_decoder
   import computer_pkg::*;
(
   input  logic [3:0] opcode,
   output iclass_t    iclass,
   output logic [3:0] alu_op,
   output jcond_t     jump_cond
);

   // Opcode to class / ALU op / branch condition lookup
   always_comb begin
      iclass    = IC_ILLEGAL;
      alu_op    = ALU_ADD;
      jump_cond = JC_NONE;
      case (opcode)
         OP_HALT:  iclass = IC_HALT;
         OP_LOAD:  iclass = IC_LOAD;
         OP_STORE: iclass = IC_STORE;
         OP_ADD: begin
            iclass = IC_MEM_ALU;
            alu_op = ALU_ADD;
         end
         OP_SUB: begin
            iclass = IC_MEM_ALU;
            alu_op = ALU_SUB;
         end
         OP_AND: begin
            iclass = IC_MEM_ALU;
            alu_op = ALU_AND;
         end
         OP_OR: begin
            iclass = IC_MEM_ALU;
            alu_op = ALU_OR;
         end
         OP_XOR: begin
            iclass = IC_MEM_ALU;
            alu_op = ALU_XOR;
         end
         OP_SHL: begin
            iclass = IC_SHIFT;
            alu_op = ALU_SHL;
         end
         OP_SHR: begin
            iclass = IC_SHIFT;
            alu_op = ALU_SHR;
         end
         OP_JUMP: begin
            iclass    = IC_JUMP;
            jump_cond = JC_ALWAYS;
         end
         OP_JUMPZ: begin
            iclass    = IC_JUMP;
            jump_cond = JC_ZERO;
         end
         OP_JUMPN: begin
            iclass    = IC_JUMP;
            jump_cond = JC_NEG;
         end
         default: iclass = IC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the accumulator computer. Drives the
// register write enables and mux selects, the ALU opcode and the memory
// write enable, one instruction at a time.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_HALT | idle, waiting for start
// S_F0   | MAR <- PC
// S_F1   | memory reads MAR, PC <- PC+1
// S_F2   | MBR <- memory data
// S_F3   | IR <- MBR
// S_DEC  | dispatch on opcode (HALT retires here, illegal sets error)
// S_E0   | operand address to MAR / store setup / shift / branch
// S_E1   | operand memory read, or store write
// S_E2   | MBR <- operand
// S_E3   | ACC <- MBR or ALU result
module control_sequencer
   import computer_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        step_mode,
   input  logic [15:0] ir,
   input  logic        acc_zero,
   input  logic        acc_neg,
   output logic        pc_write,
   output logic        pc_sel,
   output logic        mar_write,
   output logic        mar_sel,
   output logic        mbr_write,
   output logic        mbr_sel,
   output logic        ir_write,
   output logic        acc_write,
   output logic        acc_sel,
   output logic        mem_write,
   output logic [3:0]  alu_op,
   output logic        halted,
   output logic        error,
   output logic        instr_retired
);

   state_t     state_q;
   state_t     state_d;
   logic       error_q;
   logic       error_d;
   logic       retire;
   iclass_t    iclass;
   logic [3:0] dec_alu_op;
   jcond_t     jump_cond;
   logic       jump_taken;

   // The address field is consumed by the datapath muxes, not by the sequencer.
   logic       unused_ir_addr;
   assign unused_ir_addr = ^ir[11:0];

   instr_decoder u_instr_decoder (
      .opcode    (ir[15:12]),
      .iclass    (iclass),
      .alu_op    (dec_alu_op),
      .jump_cond (jump_cond)
   );

   assign jump_taken = branch_taken(jump_cond, acc_zero, acc_neg);
   assign error      = error_q;

   // State and sticky error registers; reset parks the sequencer in S_HALT
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_HALT;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         error_q <= error_d;
      end
   end

   // Next-state and strobe decode from the current state and IR
   always_comb begin
      state_d       = state_q;
      error_d       = error_q;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_sel        = PC_SEL_INC;
      mar_write     = 1'b0;
      mar_sel       = MAR_SEL_PC;
      mbr_write     = 1'b0;
      mbr_sel       = MBR_SEL_MEM;
      ir_write      = 1'b0;
      acc_write     = 1'b0;
      acc_sel       = ACC_SEL_MBR;
      mem_write     = 1'b0;
      alu_op        = ALU_ADD;
      halted        = 1'b0;
      instr_retired = 1'b0;

      case (state_q)
         S_HALT: begin
            halted = 1'b1;
            if (start) begin
               state_d = S_F0;
               error_d = 1'b0;
            end
         end
         S_F0: begin
            mar_write = 1'b1;
            mar_sel   = MAR_SEL_PC;
            state_d   = S_F1;
         end
         S_F1: begin
            pc_write = 1'b1;
            pc_sel   = PC_SEL_INC;
            state_d  = S_F2;
         end
         S_F2: begin
            mbr_write = 1'b1;
            mbr_sel   = MBR_SEL_MEM;
            state_d   = S_F3;
         end
         S_F3: begin
            ir_write = 1'b1;
            state_d  = S_DEC;
         end
         S_DEC: begin
            case (iclass)
               IC_HALT: begin
                  instr_retired = 1'b1;
                  state_d       = S_HALT;
               end
               IC_ILLEGAL: begin
                  error_d = 1'b1;
                  state_d = S_HALT;
               end
               default: state_d = S_E0;
            endcase
         end
         S_E0: begin
            case (iclass)
               IC_MEM_ALU, IC_LOAD: begin
                  mar_write = 1'b1;
                  mar_sel   = MAR_SEL_IR;
                  state_d   = S_E1;
               end
               IC_STORE: begin
                  mar_write = 1'b1;
                  mar_sel   = MAR_SEL_IR;
                  mbr_write = 1'b1;
                  mbr_sel   = MBR_SEL_ACC;
                  state_d   = S_E1;
               end
               IC_SHIFT: begin
                  acc_write = 1'b1;
                  acc_sel   = ACC_SEL_ALU;
                  alu_op    = dec_alu_op;
                  retire    = 1'b1;
               end
               IC_JUMP: begin
                  // Untaken branches retire with the PC left alone.
                  pc_write = jump_taken;
                  pc_sel   = jump_taken ? PC_SEL_IR : PC_SEL_INC;
                  retire   = 1'b1;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_E1: begin
            case (iclass)
               IC_STORE: begin
                  mem_write = 1'b1;
                  retire    = 1'b1;
               end
               IC_MEM_ALU, IC_LOAD: state_d = S_E2;
               default:             state_d = S_HALT;
            endcase
         end
         S_E2: begin
            mbr_write = 1'b1;
            mbr_sel   = MBR_SEL_MEM;
            state_d   = S_E3;
         end
         S_E3: begin
            acc_write = 1'b1;
            if (iclass == IC_MEM_ALU) begin
               acc_sel = ACC_SEL_ALU;
               alu_op  = dec_alu_op;
            end else begin
               acc_sel = ACC_SEL_MBR;
            end
            retire = 1'b1;
         end
         default: state_d = S_HALT;
      endcase

      // step_mode only matters on the retire cycle.
      if (retire) begin
         instr_retired = 1'b1;
         state_d       = step_mode ? S_HALT : S_F0;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small datapath harness (registers, memory,
// ALU) driven by the DUT strobes, plus an instruction-level model that
// predicts the per-cycle strobe pattern of every instruction it executes.
module tb_control_sequencer;

   typedef struct packed {
      logic       pc_write;
      logic       pc_sel;
      logic       mar_write;
      logic       mar_sel;
      logic       mbr_write;
      logic       mbr_sel;
      logic       ir_write;
      logic       acc_write;
      logic       acc_sel;
      logic       mem_write;
      logic [3:0] alu_op;
      logic       halted;
      logic       error;
      logic       retired;
   } vec_t;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        step_mode;
   logic [15:0] ir;
   logic        acc_zero;
   logic        acc_neg;
   logic        pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel;
   logic        ir_write, acc_write, acc_sel, mem_write;
   logic [3:0]  alu_op;
   logic        halted, error, instr_retired;

   int n_checks;
   int n_errors;

   control_sequencer dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .step_mode     (step_mode),
      .ir            (ir),
      .acc_zero      (acc_zero),
      .acc_neg       (acc_neg),
      .pc_write      (pc_write),
      .pc_sel        (pc_sel),
      .mar_write     (mar_write),
      .mar_sel       (mar_sel),
      .mbr_write     (mbr_write),
      .mbr_sel       (mbr_sel),
      .ir_write      (ir_write),
      .acc_write     (acc_write),
      .acc_sel       (acc_sel),
      .mem_write     (mem_write),
      .alu_op        (alu_op),
      .halted        (halted),
      .error         (error),
      .instr_retired (instr_retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- datapath harness ----------------
   bit [15:0] h_mem [0:4095];
   bit [15:0] pc, mar, mbr, ir_r, acc, mem_dout, alu_res;
   logic        tb_mem_we;
   logic [11:0] tb_addr;
   logic [15:0] tb_data;
   logic        tb_pc_load;
   logic [15:0] tb_pc_val;

   assign ir       = ir_r;
   assign acc_zero = (acc == 16'h0000);
   assign acc_neg  = acc[15];

   always_comb begin
      alu_res = 16'h0000;
      case (alu_op)
         4'b0000: alu_res = acc + mbr;
         4'b0001: alu_res = acc - mbr;
         4'b1000: alu_res = acc & mbr;
         4'b1001: alu_res = acc | mbr;
         4'b1010: alu_res = acc ^ mbr;
         4'b0100: alu_res = acc << 1;
         4'b0101: alu_res = acc >> 1;
         default: alu_res = 16'hDEAD;
      endcase
   end

   always @(posedge clock) begin
      if (tb_mem_we) h_mem[tb_addr] <= tb_data;
      if (mem_write) h_mem[mar[11:0]] <= mbr;
      mem_dout <= h_mem[mar[11:0]];
      if (tb_pc_load)     pc <= tb_pc_val;
      else if (pc_write)  pc <= pc_sel ? {4'h0, ir_r[11:0]} : pc + 16'd1;
      if (mar_write) mar <= mar_sel ? {4'h0, ir_r[11:0]} : pc;
      if (mbr_write) mbr <= mbr_sel ? acc : mem_dout;
      if (ir_write)  ir_r <= mbr;
      if (acc_write) acc <= acc_sel ? alu_res : mbr;
   end

   // ---------------- instruction-level model ----------------
   bit [15:0] m_mem [0:4095];
   bit [15:0] m_pc, m_acc;
   bit        m_err, m_stop, m_ill, m_cont, m_commit;
   bit        m_st_pend;
   bit [11:0] m_st_addr;
   bit [15:0] m_st_data;
   vec_t      q[$];
   int        rets[$];
   int        cyc;
   vec_t      act;

   assign act = {pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel, ir_write,
                 acc_write, acc_sel, mem_write, alu_op, halted, error, instr_retired};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   task automatic check_vec(input vec_t e);
      n_checks++;
      if (act !== e) begin
         n_errors++;
         $display("FAIL cycle_vec t=%0t icycle=%0d got=%05h want=%05h", $time, cyc, act, e);
      end
   endtask

   // Expands one instruction into its expected per-cycle strobe pattern and
   // applies its architectural effect (store deferred until it retires).
   task automatic build();
      bit [15:0] w, opnd;
      bit [3:0]  op;
      bit [11:0] a;
      bit        taken;
      vec_t      e;
      w = m_mem[m_pc[11:0]];
      m_pc = m_pc + 16'd1;
      op = w[15:12];
      a = w[11:0];
      m_stop = 1'b0;
      m_ill = 1'b0;
      e = '0; e.mar_write = 1'b1; q.push_back(e);
      e = '0; e.pc_write  = 1'b1; q.push_back(e);
      e = '0; e.mbr_write = 1'b1; q.push_back(e);
      e = '0; e.ir_write  = 1'b1; q.push_back(e);
      e = '0;
      if (op == 4'h0) begin
         e.retired = 1'b1; q.push_back(e); m_stop = 1'b1;
      end else if (op >= 4'hD) begin
         q.push_back(e); m_ill = 1'b1; m_stop = 1'b1;
      end else begin
         q.push_back(e);
         if (op == 4'h1 || (op >= 4'h3 && op <= 4'h7)) begin
            opnd = m_mem[a];
            e = '0; e.mar_write = 1'b1; e.mar_sel = 1'b1; q.push_back(e);
            e = '0; q.push_back(e);
            e = '0; e.mbr_write = 1'b1; q.push_back(e);
            e = '0; e.acc_write = 1'b1; e.retired = 1'b1;
            if (op != 4'h1) e.acc_sel = 1'b1;
            case (op)
               4'h1: m_acc = opnd;
               4'h3: begin e.alu_op = 4'b0000; m_acc = m_acc + opnd; end
               4'h4: begin e.alu_op = 4'b0001; m_acc = m_acc - opnd; end
               4'h5: begin e.alu_op = 4'b1000; m_acc = m_acc & opnd; end
               4'h6: begin e.alu_op = 4'b1001; m_acc = m_acc | opnd; end
               default: begin e.alu_op = 4'b1010; m_acc = m_acc ^ opnd; end
            endcase
            q.push_back(e);
         end else if (op == 4'h2) begin
            e = '0; e.mar_write = 1'b1; e.mar_sel = 1'b1; e.mbr_write = 1'b1; e.mbr_sel = 1'b1;
            q.push_back(e);
            e = '0; e.mem_write = 1'b1; e.retired = 1'b1; q.push_back(e);
            m_st_pend = 1'b1; m_st_addr = a; m_st_data = m_acc;
         end else if (op == 4'h8 || op == 4'h9) begin
            e = '0; e.acc_write = 1'b1; e.acc_sel = 1'b1; e.retired = 1'b1;
            e.alu_op = (op == 4'h8) ? 4'b0100 : 4'b0101;
            m_acc = (op == 4'h8) ? (m_acc << 1) : (m_acc >> 1);
            q.push_back(e);
         end else begin
            taken = (op == 4'hA) || (op == 4'hB && m_acc == 16'h0) || (op == 4'hC && m_acc[15]);
            e = '0; e.pc_write = taken; e.pc_sel = taken; e.retired = 1'b1;
            if (taken) m_pc = {4'h0, a};
            q.push_back(e);
         end
      end
   endtask

   // Compare process: mid-cycle, checks every DUT output against the model
   always @(negedge clock) begin
      vec_t e;
      if (!reset_n) begin
         q.delete();
         m_err = 1'b0; m_cont = 1'b0; m_commit = 1'b0; m_st_pend = 1'b0;
         e = '0; e.halted = 1'b1;
         check_vec(e);
      end else begin
         if (tb_mem_we) m_mem[tb_addr] = tb_data;
         if (tb_pc_load) m_pc = tb_pc_val;
         if (m_commit) begin
            if (m_st_pend) m_mem[m_st_addr] = m_st_data;
            m_st_pend = 1'b0;
            m_commit = 1'b0;
         end
         if (m_cont) begin
            m_cont = 1'b0;
            build();
         end
         if (q.size() == 0) begin
            e = '0; e.halted = 1'b1; e.error = m_err;
            check_vec(e);
            if (start) begin
               m_err = 1'b0; rets.delete(); cyc = 0; m_cont = 1'b1;
            end
         end else begin
            e = q.pop_front();
            cyc++;
            check_vec(e);
            if (q.size() == 0) begin
               if (e.retired) rets.push_back(cyc);
               if (m_ill) m_err = 1'b1;
               m_commit = 1'b1;
               m_cont = !(m_stop || step_mode);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Main flow stays at posedge+2 between tasks.
   task automatic poke(input logic [11:0] a, input logic [15:0] d);
      tb_mem_we = 1'b1; tb_addr = a; tb_data = d;
      @(posedge clock); #2;
      tb_mem_we = 1'b0;
   endtask

   task automatic set_pc(input logic [15:0] v);
      tb_pc_load = 1'b1; tb_pc_val = v;
      @(posedge clock); #2;
      tb_pc_load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #2;
      start = 1'b0;
   endtask

   task automatic wait_halt(input int max_cyc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         @(negedge clock); #1;
         if (halted && q.size() == 0 && !m_cont) done = 1'b1;
      end
      chk("halt_timeout", {31'd0, done}, 32'd1);
      @(posedge clock); #2;
   endtask

   task automatic chk_rets1(input string name, input int r0);
      chk({name, "_nret"}, rets.size(), 1);
      if (rets.size() >= 1) chk({name, "_ret0"}, rets[0], r0);
   endtask

   initial begin
      bit seen;
      n_checks = 0; n_errors = 0;
      reset_n = 1'b0; start = 1'b0; step_mode = 1'b0;
      tb_mem_we = 1'b0; tb_addr = '0; tb_data = '0;
      tb_pc_load = 1'b0; tb_pc_val = '0;
      #1;
      chk("rst_halted", halted, 1);
      chk("rst_error", error, 0);
      chk("rst_retired", instr_retired, 0);
      chk("rst_strobes", {pc_write, mar_write, mbr_write, ir_write, acc_write, mem_write}, 0);
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock); #2;

      // LOAD 0x10, ADD 0x11, STORE 0x12, HALT
      poke(12'h010, 16'd5);
      poke(12'h011, 16'd7);
      poke(12'h000, 16'h1010);
      poke(12'h001, 16'h3011);
      poke(12'h002, 16'h2012);
      poke(12'h003, 16'h0000);
      set_pc(16'h0000);
      chk("pre_start_halted", halted, 1);
      pulse_start();
      @(negedge clock); #1;
      chk("f0_halted", halted, 0);
      chk("f0_mar_write", mar_write, 1);
      @(negedge clock); #1;
      chk("f1_pc_write", pc_write, 1);
      @(negedge clock); #1;
      chk("f2_mbr_write", mbr_write, 1);
      @(negedge clock); #1;
      chk("f3_ir_write", ir_write, 1);
      @(posedge clock); #2;
      wait_halt(100);
      chk("p1_nret", rets.size(), 4);
      if (rets.size() == 4) begin
         chk("p1_ret_load", rets[0], 9);
         chk("p1_ret_add", rets[1], 18);
         chk("p1_ret_store", rets[2], 25);
         chk("p1_ret_halt", rets[3], 30);
      end
      chk("p1_mem12", h_mem[12'h012], 16'd12);
      chk("p1_halted", halted, 1);

      // Step mode: LOAD, then JUMPZ untaken, LOAD 0, JUMPZ taken
      step_mode = 1'b1;
      poke(12'h013, 16'h0000);
      poke(12'h040, 16'h1010);
      poke(12'h041, 16'hB020);
      poke(12'h042, 16'h1013);
      poke(12'h043, 16'hB020);
      set_pc(16'h0040);
      pulse_start();
      wait_halt(40);
      chk_rets1("step_load", 9);
      chk("step_acc", acc, 16'd5);
      pulse_start();
      wait_halt(40);
      chk_rets1("jz_untaken", 6);
      chk("jz_untaken_pc", pc, 16'h0042);
      pulse_start();
      wait_halt(40);
      chk_rets1("step_load0", 9);
      pulse_start();
      wait_halt(40);
      chk_rets1("jz_taken", 6);
      chk("jz_taken_pc", pc, 16'h0020);

      // Free run through SUB, JUMPN, SHL, XOR, OR, AND, SHR, STORE, JUMP, HALT
      step_mode = 1'b0;
      poke(12'h020, 16'h4011);
      poke(12'h021, 16'hC028);
      poke(12'h028, 16'h8000);
      poke(12'h029, 16'h7010);
      poke(12'h02A, 16'h6011);
      poke(12'h02B, 16'h5010);
      poke(12'h02C, 16'h9000);
      poke(12'h02D, 16'h2014);
      poke(12'h02E, 16'hA030);
      poke(12'h030, 16'h0000);
      pulse_start();
      repeat (3) @(posedge clock);
      #2;
      pulse_start();
      wait_halt(200);
      chk("run_mem14", h_mem[12'h014], 16'h0002);
      chk("run_acc", acc, 16'h0002);
      chk("run_pc", pc, 16'h0031);
      chk("run_nret", rets.size(), 10);

      // Illegal opcode, then restart clears error
      poke(12'h050, 16'hE000);
      poke(12'h051, 16'h0000);
      set_pc(16'h0050);
      pulse_start();
      wait_halt(40);
      chk("ill_error", error, 1);
      chk("ill_halted", halted, 1);
      chk("ill_nret", rets.size(), 0);
      pulse_start();
      @(negedge clock); #1;
      chk("restart_error_clr", error, 0);
      @(posedge clock); #2;
      wait_halt(40);
      chk_rets1("restart_halt", 5);

      // Reset during STORE S_E1
      step_mode = 1'b1;
      poke(12'h015, 16'hBEEF);
      poke(12'h060, 16'h2015);
      set_pc(16'h0060);
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock); #1;
         if (mem_write) seen = 1'b1;
      end
      chk("rst_store_seen", {31'd0, seen}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_mid_mem_write", mem_write, 0);
      chk("rst_mid_halted", halted, 1);
      @(posedge clock); #2;
      chk("rst_mid_mem15", h_mem[12'h015], 16'hBEEF);
      @(posedge clock); #2;
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      chk("post_rst_halted", halted, 1);
      chk("final_acc_model", acc, m_acc);
      chk("final_pc_model", pc, m_pc);
      chk("final_mem15_model", h_mem[12'h015], m_mem[12'h015]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
